// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if
// Groups the core-side request/response signals and the memory-bus signals
// used by dmem_bridge.
//   master : the bridge view. It takes core requests and memory-bus replies.
//            It drives responses, the error count and the bus request.
//   slave  : the environment view. This is the core plus the memory model.
// Core side  : req_valid/we/addr/wdata/be in; rsp_valid/rdata/err, err_count out
// Memory bus : mem_valid/we/addr/wdata/be out; mem_ready, mem_rvalid/rdata in
interface dmem_bridge_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_count;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_rdata, rsp_err, err_count,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_rdata, rsp_err, err_count,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge
// Data-memory access controller between the core's load/store path and a
// valid/ready memory bus with variable latency. It handles one outstanding
// access at a time. Addresses outside the data window fault without any
// bus traffic. A bus phase that stalls for TIMEOUT cycles is aborted as a
// fault.
// Ports:
//   clk    : the single clock; all state changes on the rising edge
//   n_rst  : asynchronous, active-low reset
//   bus    : dmem_bridge_if.master; core request/response and memory bus
// Parameters:
//   DMEM_BASE : base address of the data window
//   DMEM_AW   : the window spans 2**DMEM_AW bytes
//   TIMEOUT   : cycles allowed in REQ/RWAIT before the access is aborted
module dmem_bridge #(
    parameter logic [31:0] DMEM_BASE = 32'h1000_0000,
    parameter int          DMEM_AW   = 16,
    parameter int          TIMEOUT   = 255
) (
    input logic           clk,
    input logic           n_rst,
    dmem_bridge_if.master bus
);
    // One bit of headroom keeps the counter from wrapping past TIMEOUT.
    localparam int               CNT_W    = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RWAIT,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] to_cnt;
    logic             in_window;
    logic             unused_addr_lsb;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_window = (bus.req_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]);

    // The byte offset never reaches the bus; lane steering happens upstream.
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // All outputs are registered here. There is no combinational path from
    // the mem_* inputs to the rsp_* outputs. The fault counter is bumped
    // on entry to RESP. It therefore already counts the current fault when
    // rsp_err is seen.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            to_cnt        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.err_count <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    if (bus.req_valid) begin
                        if (in_window) begin
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wdata <= bus.req_wdata;
                            bus.mem_be    <= bus.req_be;
                            bus.mem_valid <= 1'b1;
                            to_cnt        <= '0;
                            state         <= REQ;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.err_count <= sat_inc8(bus.err_count);
                            state         <= RESP;
                        end
                    end
                end

                REQ: begin
                    // A handshake counts as progress and wins over the timeout.
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        to_cnt        <= to_cnt + 1'b1;
                        if (bus.mem_we) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_rdata <= '0;
                            state         <= RESP;
                        end else begin
                            state <= RWAIT;
                        end
                    end else if (to_cnt >= TO_LIMIT) begin
                        bus.mem_valid <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.err_count <= sat_inc8(bus.err_count);
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                RWAIT: begin
                    // mem_rvalid is only looked at here. A strobe in the
                    // handshake cycle or after an abort is ignored.
                    if (bus.mem_rvalid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= bus.mem_rdata;
                        state         <= RESP;
                    end else if (to_cnt >= TO_LIMIT) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.err_count <= sat_inc8(bus.err_count);
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    bus.mem_valid <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
// Directed bench for dmem_bridge, built with TIMEOUT = 4. Inputs change 1 ns
// after the rising edge and outputs are sampled on the falling edge. Cycle 0
// is the cycle in which a request is first presented.
module tb_dmem_bridge;
    logic clk;
    logic n_rst;
    int   vectors;
    int   miscompares;

    dmem_bridge_if bus();

    dmem_bridge #(
        .DMEM_BASE(32'h1000_0000),
        .DMEM_AW  (16),
        .TIMEOUT  (4)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_be = '0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        #2;
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        vectors++; if (bus.err_count !== 8'h0) begin miscompares++; $display("FAIL reset_err_count: got %0d want 0", bus.err_count); end
        vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        vectors++; if ({bus.mem_we, bus.mem_be, bus.mem_wdata} !== 37'h0) begin miscompares++; $display("FAIL reset_mem_misc: got we=%b be=%b wdata=%h want all 0", bus.mem_we, bus.mem_be, bus.mem_wdata); end
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic test_store();
        bus.mem_ready = 1'b1;
        tick();
        set_req(1'b1, 32'h1000_0104, 32'hA5A5_0000, 4'b1100);
        @(negedge clk);
        vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL store_c0_mem_valid: got %b want 0", bus.mem_valid); end
        tick();
        @(negedge clk);
        vectors++; if (bus.mem_valid !== 1'b1) begin miscompares++; $display("FAIL store_c1_mem_valid: got %b want 1", bus.mem_valid); end
        vectors++; if (bus.mem_addr !== 32'h1000_0104) begin miscompares++; $display("FAIL store_c1_mem_addr: got %h want 10000104", bus.mem_addr); end
        vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL store_c1_mem_we: got %b want 1", bus.mem_we); end
        vectors++; if (bus.mem_be !== 4'b1100) begin miscompares++; $display("FAIL store_c1_mem_be: got %b want 1100", bus.mem_be); end
        vectors++; if (bus.mem_wdata !== 32'hA5A5_0000) begin miscompares++; $display("FAIL store_c1_mem_wdata: got %h want a5a50000", bus.mem_wdata); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL store_c1_rsp_valid: got %b want 0", bus.rsp_valid); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL store_c2_rsp_valid: got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL store_c2_rsp_err: got %b want 0", bus.rsp_err); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL store_c2_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL store_c2_mem_valid: got %b want 0", bus.mem_valid); end
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL store_c3_rsp_valid: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_load_wait();
        tick();
        set_req(1'b0, 32'h1000_0202, 32'h0, 4'b1111);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                // The handshake cycle carries a bogus rvalid that must be ignored.
                bus.mem_ready  = 1'b1;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            vectors++; if (bus.mem_valid !== 1'b1) begin miscompares++; $display("FAIL load_c%0d_mem_valid: got %b want 1", c, bus.mem_valid); end
            vectors++; if (bus.mem_addr !== 32'h1000_0200) begin miscompares++; $display("FAIL load_c%0d_mem_addr: got %h want 10000200", c, bus.mem_addr); end
            vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL load_c%0d_mem_we: got %b want 0", c, bus.mem_we); end
        end
        tick();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL load_c4_mem_valid: got %b want 0", bus.mem_valid); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL load_c4_rsp_valid: got %b want 0", bus.rsp_valid); end
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL load_c5_rsp_valid: got %b want 0", bus.rsp_valid); end
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL load_c6_rsp_valid: got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_c6_rsp_rdata: got %h want deadbeef", bus.rsp_rdata); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL load_c6_rsp_err: got %b want 0", bus.rsp_err); end
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL load_c7_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL load_c7_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    endtask

    // Both addresses sit just outside the window: one far away, one at the top edge.
    task automatic test_out_of_window();
        logic [31:0] addrs [2];
        addrs[0] = 32'h2000_0000;
        addrs[1] = 32'h1001_0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            set_req(1'b0, addrs[i], 32'h0, 4'b1111);
            @(negedge clk);
            vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL oow%0d_c0_mem_valid: got %b want 0", i, bus.mem_valid); end
            tick();
            @(negedge clk);
            vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL oow%0d_c1_rsp_valid: got %b want 1", i, bus.rsp_valid); end
            vectors++; if (bus.rsp_err !== 1'b1) begin miscompares++; $display("FAIL oow%0d_c1_rsp_err: got %b want 1", i, bus.rsp_err); end
            vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL oow%0d_c1_rsp_rdata: got %h want 0", i, bus.rsp_rdata); end
            vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL oow%0d_c1_mem_valid: got %b want 0", i, bus.mem_valid); end
            tick();
            bus.req_valid = 1'b0;
            @(negedge clk);
            vectors++; if (bus.err_count !== 8'(i + 1)) begin miscompares++; $display("FAIL oow%0d_err_count: got %0d want %0d", i, bus.err_count, i + 1); end
            vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL oow%0d_c2_rsp_valid: got %b want 0", i, bus.rsp_valid); end
        end
    endtask

    task automatic test_timeout();
        tick();
        set_req(1'b0, 32'h1000_0010, 32'h0, 4'b1111);
        for (int c = 1; c <= 5; c++) begin
            tick();
            @(negedge clk);
            vectors++; if (bus.mem_valid !== 1'b1) begin miscompares++; $display("FAIL to_c%0d_mem_valid: got %b want 1", c, bus.mem_valid); end
            vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL to_c%0d_rsp_valid: got %b want 0", c, bus.rsp_valid); end
        end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL to_c6_rsp_valid: got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_err !== 1'b1) begin miscompares++; $display("FAIL to_c6_rsp_err: got %b want 1", bus.rsp_err); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL to_c6_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL to_c6_mem_valid: got %b want 0", bus.mem_valid); end
        tick();
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL to_c7_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.err_count !== 8'd3) begin miscompares++; $display("FAIL to_err_count: got %0d want 3", bus.err_count); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL to_stray_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL to_stray_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        // A follow-up store at the top word of the window with all lanes off.
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ready  = 1'b1;
        set_req(1'b1, 32'h1000_FFFF, 32'h1122_3344, 4'b0000);
        @(negedge clk);
        vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL st2_c0_mem_valid: got %b want 0", bus.mem_valid); end
        tick();
        @(negedge clk);
        vectors++; if (bus.mem_valid !== 1'b1) begin miscompares++; $display("FAIL st2_c1_mem_valid: got %b want 1", bus.mem_valid); end
        vectors++; if (bus.mem_addr !== 32'h1000_FFFC) begin miscompares++; $display("FAIL st2_c1_mem_addr: got %h want 1000fffc", bus.mem_addr); end
        vectors++; if (bus.mem_be !== 4'b0000) begin miscompares++; $display("FAIL st2_c1_mem_be: got %b want 0000", bus.mem_be); end
        vectors++; if (bus.mem_wdata !== 32'h1122_3344) begin miscompares++; $display("FAIL st2_c1_mem_wdata: got %h want 11223344", bus.mem_wdata); end
        vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL st2_c1_mem_we: got %b want 1", bus.mem_we); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL st2_c2_rsp_valid: got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL st2_c2_rsp_err: got %b want 0", bus.rsp_err); end
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus.err_count !== 8'd3) begin miscompares++; $display("FAIL st2_err_count: got %0d want 3", bus.err_count); end
    endtask

    task automatic test_reset_rwait();
        bus.mem_ready = 1'b1;
        tick();
        set_req(1'b0, 32'h1000_0300, 32'h55AA_55AA, 4'b1111);
        tick();
        @(negedge clk);
        vectors++; if (bus.mem_valid !== 1'b1) begin miscompares++; $display("FAIL rr_c1_mem_valid: got %b want 1", bus.mem_valid); end
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 32'h1000_0300) begin miscompares++; $display("FAIL rr_c2_mem_addr: got %h want 10000300", bus.mem_addr); end
        #1;
        n_rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL rr_mem_valid: got %b want 0", bus.mem_valid); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rr_mem_addr: got %h want 0", bus.mem_addr); end
        vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rr_mem_wdata: got %h want 0", bus.mem_wdata); end
        vectors++; if (bus.mem_be !== 4'h0) begin miscompares++; $display("FAIL rr_mem_be: got %b want 0", bus.mem_be); end
        vectors++; if (bus.err_count !== 8'h0) begin miscompares++; $display("FAIL rr_err_count: got %0d want 0", bus.err_count); end
        vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_we} !== 35'h0) begin miscompares++; $display("FAIL rr_rsp: got v=%b e=%b d=%h we=%b want all 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_we); end
        tick();
        tick();
        n_rst = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        set_req(1'b0, 32'h1000_0404, 32'h0, 4'b1111);
        tick();
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 32'h1000_0404) begin miscompares++; $display("FAIL rr2_c1_mem_addr: got %h want 10000404", bus.mem_addr); end
        tick();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rr2_c2_rsp_valid: got %b want 0", bus.rsp_valid); end
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rr2_c3_rsp_valid: got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rr2_c3_rsp_rdata: got %h want cafef00d", bus.rsp_rdata); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL rr2_c3_rsp_err: got %b want 0", bus.rsp_err); end
        tick();
        bus.req_valid = 1'b0;
    endtask

    // req_valid stays high through 260 faulting requests: responses land in
    // odd cycles with one IDLE cycle between them.
    task automatic test_back_to_back_saturation();
        int want_cnt;
        tick();
        set_req(1'b0, 32'h3000_0000, 32'h0, 4'b1111);
        for (int c = 0; c < 520; c++) begin
            @(negedge clk);
            vectors++; if (bus.rsp_valid !== 1'(c % 2)) begin miscompares++; $display("FAIL b2b_c%0d_rsp_valid: got %b want %0d", c, bus.rsp_valid, c % 2); end
            vectors++; if (bus.mem_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_c%0d_mem_valid: got %b want 0", c, bus.mem_valid); end
            if (c % 2 == 0 && c > 0) begin
                want_cnt = (c / 2 > 255) ? 255 : c / 2;
                vectors++; if (bus.err_count !== 8'(want_cnt)) begin miscompares++; $display("FAIL b2b_c%0d_err_count: got %0d want %0d", c, bus.err_count, want_cnt); end
            end
            tick();
            if (c == 519) bus.req_valid = 1'b0;
        end
        @(negedge clk);
        vectors++; if (bus.err_count !== 8'd255) begin miscompares++; $display("FAIL b2b_final_err_count: got %0d want 255", bus.err_count); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_final_rsp_valid: got %b want 0", bus.rsp_valid); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_rsp_valid: got %b want 0", bus.rsp_valid); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_store();
        test_load_wait();
        test_out_of_window();
        test_timeout();
        test_reset_rwait();
        test_back_to_back_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory access controller sitting directly downstream of the single-cycle datapath's load/store path. It accepts one lane-aligned load or store request (address, write data, byte enables) from the core and runs it on a valid/ready memory bus with variable latency. It returns raw read words to the core's byte-extract logic. It also flags out-of-window addresses and bus timeouts.

## Interface
- `DMEM_BASE`, default `32'h1000_0000`: base address of the data window.
- `DMEM_AW`, default `16`: window size is `2**DMEM_AW` bytes.
- `TIMEOUT`, default `255`: number of cycles the bridge waits in a bus state before aborting.
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `n_rst`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: core has a load or store pending. Held with stable fields until `rsp_valid`.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data, already lane-aligned.
- `req_be`, input, 4: byte enables.
- `rsp_valid`, output, 1: one-cycle completion pulse.
- `rsp_rdata`, output, 32: raw load word. It is 0 for stores and errors.
- `rsp_err`, output, 1: the access faulted. Qualified by `rsp_valid`.
- `err_count`, output, 8: saturating count of faulted accesses.
- `mem_valid`, output, 1: bus request.
- `mem_ready`, input, 1: bus accepts the request.
- `mem_we`, output, 1: bus write strobe.
- `mem_addr`, output, 32: word address, equal to `{addr[31:2], 2'b00}`.
- `mem_wdata`, output, 32: bus write data.
- `mem_be`, output, 4: bus byte enables.
- `mem_rvalid`, input, 1: read data is valid.
- `mem_rdata`, input, 32: bus read data.

## Operation
- FSM states: `IDLE`, `REQ`, `RWAIT`, `RESP`.
- **IDLE**
  - Samples `req_valid`.
  - In-window test: `req_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]`.
  - Out of window: go to `RESP` with err=1 and no bus activity.
  - In window: register we/addr/wdata/be, clear the timeout counter, go to `REQ`.
- **REQ**
  - `mem_valid` = 1. All `mem_*` outputs are driven from the capture registers and stay stable until `mem_ready`.
  - On `mem_ready`: a store goes to `RESP` with err=0; a load goes to `RWAIT`.
- **RWAIT**
  - `mem_valid` = 0.
  - On `mem_rvalid`: capture `mem_rdata`, go to `RESP` with err=0.
  - The earliest legal `mem_rvalid` is the cycle after the `mem_ready` handshake. `mem_rvalid` in the handshake cycle itself is ignored.
- **Timeout**
  - The counter increments in every `REQ`/`RWAIT` cycle and resets on entry to `REQ`.
  - When it reaches `TIMEOUT` without progress: go to `RESP`, err=1, rdata=0, and drop `mem_valid` immediately.
  - A late `mem_rvalid` arriving in `RESP` or `IDLE` is ignored.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle, with registered `rsp_rdata`/`rsp_err`.
  - If err=1, `err_count` increments, saturating at 255.
  - Next state is always `IDLE`.
- **Back-to-back:** `req_valid` high in the cycle after `RESP` is treated as a new request.
- **Pass-through:**
  - Data and byte enables go to the bus unmodified; lane steering is done upstream.
  - `req_be == 0` is forwarded as-is; no special case.
  - `req_addr[1:0]` is not forwarded; it is dropped to form the word address.
- **Outstanding transactions:** only one at a time. Request inputs are ignored outside `IDLE`.

## Timing
- **Reset values:** all outputs 0, FSM in `IDLE`, `err_count` = 0, timeout counter = 0.
- **Reset mid-transaction:** assertion forces `IDLE` asynchronously and deasserts `mem_valid` the same instant. The bus side must tolerate the abandoned request.
- **Store with zero-wait `mem_ready`:**
  - Request sampled in cycle 0.
  - `mem_valid` in cycle 1, with the handshake.
  - `rsp_valid` in cycle 2.
- **Load with zero-wait ready and `mem_rvalid` in cycle 2:** `rsp_valid` in cycle 3.
- **Out-of-window access:** `rsp_valid` in cycle 1.
- **Timeout:** with `mem_ready` never asserted, `rsp_valid`/`rsp_err` in cycle `TIMEOUT`+2.
- **Data output:** `rsp_rdata` is valid only while `rsp_valid` = 1; it returns to 0 in `IDLE`.
- **Stall:** the core derives its stall as `req_valid & ~rsp_valid`. No combinational path from `mem_*` inputs to `rsp_*` outputs.

## Test plan
- **Store:** addr `0x1000_0104`, wdata `0xA5A5_0000`, be `4'b1100`, `mem_ready` tied to 1.
  - Required: `mem_addr = 0x1000_0104`, `mem_we = 1`, `mem_be = 4'b1100` in cycle 1.
  - Required: `rsp_valid` in cycle 2 with err=0 and rdata=0.
- **Load with wait states:** addr `0x1000_0202`; `mem_ready` after 3 cycles; `mem_rvalid` 2 cycles later with `0xDEAD_BEEF`.
  - Required: `mem_addr = 0x1000_0200`, stable while `mem_valid` is high.
  - Required: `rsp_rdata = 0xDEAD_BEEF`, err=0.
- **Out of window:** load at `0x2000_0000`.
  - Required: `mem_valid` never asserts.
  - Required: `rsp_valid`/`rsp_err` in cycle 1, `err_count` = 1.
- **Timeout:** `TIMEOUT` = 4, `mem_ready` held 0.
  - Required: `rsp_err` in cycle 6.
  - Then a stray `mem_rvalid` with `0x1234_5678` in `IDLE` produces no response.
  - A following good store completes normally.
- **Reset in RWAIT:** pull `n_rst` low mid-load.
  - Required: all outputs immediately 0.
  - Required: after release, a new load completes correctly.
- **Saturation and back-to-back:** 260 consecutive out-of-window requests.
  - Required: `err_count` saturates at 255.
  - Required: each response is separated by exactly one `IDLE` cycle.
